// File: rtl/mem_load_resp_queue_pkg.sv
// Shared definitions for the MEM-stage load response queue: access-size
// encodings, default geometry and entry field widths.
package mem_load_resp_queue_pkg;

  localparam int SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
  localparam logic [SIZE_W-1:0] SZ_D = 2'd3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_TAG_W  = 5;

  // Byte-offset width for a bus of data_w bits.
  function automatic int ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_load_extract.sv
// Combinational load-data extraction: selects the byte/half/word/dword lane
// addressed by ofs and sign- or zero-extends it to the full bus width.
// Stores produce zero. On a 32-bit bus a dword request behaves as a word.
module mem_load_extract
  import mem_load_resp_queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFS_W  = ofs_w(DATA_W)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [SIZE_W-1:0] size,
  input  logic              sign,
  input  logic              is_load,
  input  logic [OFS_W-1:0]  ofs,
  output logic [DATA_W-1:0] data
);

  localparam int SHW = $clog2(DATA_W);

  logic [OFS_W-1:0]  aligned;
  logic [SHW-1:0]    pad;
  logic [DATA_W-1:0] shifted;

  // Left-justify the lane, then shift back right: arithmetic for signed
  // loads, logical for unsigned ones.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [SHW-1:0]    amt,
                                               input logic              sgn);
    logic signed [DATA_W-1:0] lj;
    lj = $signed(raw << amt);
    if (sgn) return $unsigned(lj >>> amt);
    return $unsigned(lj) >> amt;
  endfunction

  // Align the offset to the access size and pick the lane width.
  always_comb begin
    aligned = '0;
    pad     = '0;
    case (size)
      SZ_B: begin
        aligned = ofs;
        pad     = SHW'(DATA_W - 8);
      end
      SZ_H: begin
        aligned = ofs & ~OFS_W'(1);
        pad     = SHW'(DATA_W - 16);
      end
      SZ_W: begin
        aligned = ofs & ~OFS_W'(3);
        pad     = SHW'(DATA_W - 32);
      end
      default: begin
        aligned = '0;
        pad     = '0;
      end
    endcase
    shifted = rdata >> {aligned, 3'b000};
    data    = is_load ? extend(shifted, pad, sign) : '0;
  end

endmodule

// File: rtl/mem_load_resp_queue.sv
// MEM-stage load response queue. Tracks up to DEPTH outstanding data-SRAM
// requests in issue order, captures in-order data_ok responses (extracted
// and extended at capture) and holds results until WB accepts them.
// A flush discards all tracked entries and swallows their late responses.
// Optional feature: define MEM_LOAD_RESP_BYPASS_EN to forward a response for
// the head entry straight to the output in the same cycle.
module mem_load_resp_queue
  import mem_load_resp_queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int OFS_W  = ofs_w(DATA_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_load,
  input  logic [1:0]             req_size,
  input  logic                   req_sign,
  input  logic [OFS_W-1:0]       req_ofs,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic                   rsp_data_ok,
  input  logic [DATA_W-1:0]      rsp_rdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_is_load,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rsp_ptr_q, rsp_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] unresp_q, unresp_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Entry payload (not reset; only read while the entry is live)
  logic              is_load_q [DEPTH];
  logic              is_load_d [DEPTH];
  logic [SIZE_W-1:0] size_q    [DEPTH];
  logic [SIZE_W-1:0] size_d    [DEPTH];
  logic              sign_q    [DEPTH];
  logic              sign_d    [DEPTH];
  logic [OFS_W-1:0]  ofs_q     [DEPTH];
  logic [OFS_W-1:0]  ofs_d     [DEPTH];
  logic [TAG_W-1:0]  tag_q     [DEPTH];
  logic [TAG_W-1:0]  tag_d     [DEPTH];
  logic [DATA_W-1:0] data_q    [DEPTH];
  logic [DATA_W-1:0] data_d    [DEPTH];

  logic              enq, deq, route, drop_hit, byp;
  logic [CNT_W-1:0]  in_flight;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] head_data;

  // Extraction always works on the entry awaiting the next response.
  mem_load_extract #(
    .DATA_W (DATA_W),
    .OFS_W  (OFS_W)
  ) u_extract (
    .rdata   (rsp_rdata),
    .size    (size_q[rsp_ptr_q]),
    .sign    (sign_q[rsp_ptr_q]),
    .is_load (is_load_q[rsp_ptr_q]),
    .ofs     (ofs_q[rsp_ptr_q]),
    .data    (ext_data)
  );

  // Drops and live entries together bound memory-side outstanding requests.
  assign req_ready = !flush &&
                     (({1'b0, count_q} + {1'b0, drop_cnt_q}) < (CNT_W + 1)'(DEPTH));

  assign enq      = req_valid && req_ready;
  assign drop_hit = rsp_data_ok && (drop_cnt_q != '0);
  assign route    = rsp_data_ok && (drop_cnt_q == '0) && (unresp_q != '0);

`ifdef MEM_LOAD_RESP_BYPASS_EN
  assign byp = route && (rd_ptr_q == rsp_ptr_q) && !flush;
`else
  assign byp = 1'b0;
`endif

  assign out_valid   = !flush && (((count_q != '0) && done_q[rd_ptr_q]) || byp);
  assign deq         = out_valid && out_ready;
  assign head_data   = byp ? ext_data : data_q[rd_ptr_q];
  assign out_data    = out_valid ? head_data : '0;
  assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;
  assign out_is_load = out_valid ? is_load_q[rd_ptr_q] : 1'b0;
  assign pending     = count_q;
  assign in_flight   = drop_cnt_q + unresp_q;

  // Next-state: flush overrides; otherwise enqueue, capture and retire.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rsp_ptr_d  = rsp_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    unresp_d   = unresp_q;
    drop_cnt_d = drop_cnt_q;
    done_d     = done_q;
    is_load_d  = is_load_q;
    size_d     = size_q;
    sign_d     = sign_q;
    ofs_d      = ofs_q;
    tag_d      = tag_q;
    data_d     = data_q;
    if (flush) begin
      // Every request still owed a response becomes a drop; a response
      // arriving in this cycle already settles one of them.
      rsp_ptr_d  = wr_ptr_q;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      unresp_d   = '0;
      drop_cnt_d = in_flight - CNT_W'(rsp_data_ok && (in_flight != '0));
      done_d     = '0;
    end else begin
      if (enq) begin
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        is_load_d[wr_ptr_q] = req_is_load;
        size_d[wr_ptr_q]    = req_size;
        sign_d[wr_ptr_q]    = req_sign;
        ofs_d[wr_ptr_q]     = req_ofs;
        tag_d[wr_ptr_q]     = req_tag;
      end
      if (drop_hit) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (route) begin
        rsp_ptr_d          = rsp_ptr_q + PTR_W'(1);
        data_d[rsp_ptr_q]  = ext_data;
        done_d[rsp_ptr_q]  = 1'b1;
      end
      // Retire after capture so a bypassed head never stays marked done.
      if (deq) begin
        rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        done_d[rd_ptr_q] = 1'b0;
      end
      count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
      unresp_d = unresp_q + CNT_W'(enq) - CNT_W'(route);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rsp_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unresp_q   <= '0;
      drop_cnt_q <= '0;
      done_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rsp_ptr_q  <= rsp_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unresp_q   <= unresp_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
    end
  end

  // Entry payload registers.
  always_ff @(posedge clk) begin
    is_load_q <= is_load_d;
    size_q    <= size_d;
    sign_q    <= sign_d;
    ofs_q     <= ofs_d;
    tag_q     <= tag_d;
    data_q    <= data_d;
  end

endmodule
